// File: rtl/final_adder.sv
// Bit-serial final adder for the Montgomery datapath: adds the carry-save pair LSB first,
// then applies one conditional subtraction of the modulus, pulsing done when m is updated.
module final_adder #(
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start_final_addition,
  input  logic [DATA_WIDTH-1:0] s0_r,
  input  logic [DATA_WIDTH-1:0] s1_r,
  input  logic [DATA_WIDTH-1:0] n,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] m
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, ADD, SUB, FINISH} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, n_q, n_d, s_q, s_d, d_q, d_d, m_q, m_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cy_q, cy_d, c_out_q, c_out_d, bo_q, bo_d, done_q, done_d;
  logic           sum_bit, carry_nxt, diff_bit, borrow_nxt;

  // cy_q carries the add carry during ADD and is reused as the borrow during SUB.
  assign sum_bit    = a_q[0] ^ b_q[0] ^ cy_q;
  assign carry_nxt  = (a_q[0] & b_q[0]) | (cy_q & (a_q[0] ^ b_q[0]));
  assign diff_bit   = s_q[0] ^ n_q[0] ^ cy_q;
  assign borrow_nxt = (~s_q[0] & (n_q[0] | cy_q)) | (s_q[0] & n_q[0] & cy_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    s_d     = s_q;
    d_d     = d_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    c_out_d = c_out_q;
    bo_d    = bo_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start_final_addition) begin
          a_d     = s0_r;
          b_d     = s1_r;
          n_d     = n;
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        s_d   = {sum_bit, s_q[W-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = carry_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          c_out_d = carry_nxt;
          cy_d    = 1'b0;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        d_d   = {diff_bit, d_q[W-1:1]};
        s_d   = {s_q[0], s_q[W-1:1]};
        n_d   = n_q >> 1;
        cy_d  = borrow_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bo_d    = borrow_nxt;
          cnt_d   = '0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        // A carry out of the add or no borrow out of the subtract means sum >= n.
        m_d     = (c_out_q || !bo_q) ? d_q : s_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      s_q     <= '0;
      d_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      c_out_q <= 1'b0;
      bo_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      s_q     <= s_d;
      d_q     <= d_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      c_out_q <= c_out_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign m    = m_q;
endmodule

// File: tb/tb_final_adder.sv
// Directed-vector bench for final_adder at W=6: latency, correction cases, ce stalls,
// busy-start rejection, back-to-back operation and mid-operation reset.
module tb_final_adder;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ce = 1'b1;
  logic         start_final_addition = 1'b0;
  logic [W-1:0] s0_r = '0;
  logic [W-1:0] s1_r = '0;
  logic [W-1:0] n = '0;
  logic         done;
  logic [W-1:0] m;

  int checks = 0;
  int errors = 0;

  final_adder #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .start_final_addition(start_final_addition),
    .s0_r(s0_r), .s1_r(s1_r), .n(n), .done(done), .m(m)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  // Pulses start for one edge and returns the number of edges until done (0 = timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] nn,
                        output int lat);
    @(negedge clk);
    s0_r = a; s1_r = b; n = nn; start_final_addition = 1'b1;
    @(negedge clk);
    start_final_addition = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (m !== 6'd0) begin errors++; $display("FAIL reset_m actual=%0d required=0", m); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b required=0", done); end
  endtask

  task automatic test_basic();
    int lat;
    int extra;
    run_op(6'b101010, 6'b010101, 6'd0, lat);
    checks++;
    if (lat !== 13) begin errors++; $display("FAIL basic_latency actual=%0d required=13", lat); end
    checks++;
    if (m !== 6'd63) begin errors++; $display("FAIL basic_m actual=%0d required=63", m); end
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL basic_single_pulse actual=%0d extra required=0", extra); end
  endtask

  task automatic test_correction();
    int lat;
    run_op(6'd63, 6'd1, 6'd5, lat);
    checks++;
    if (lat !== 13 || m !== 6'd59) begin
      errors++; $display("FAIL overflow_sub actual=%0d lat=%0d required=59 lat=13", m, lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL overflow_done_width actual=%b required=0", done); end
    run_op(6'd1, 6'd2, 6'd10, lat);
    checks++;
    if (lat !== 13 || m !== 6'd3) begin
      errors++; $display("FAIL below_modulus actual=%0d lat=%0d required=3 lat=13", m, lat);
    end
    run_op(6'd4, 6'd6, 6'd10, lat);
    checks++;
    if (lat !== 13 || m !== 6'd0) begin
      errors++; $display("FAIL equal_modulus actual=%0d lat=%0d required=0 lat=13", m, lat);
    end
  endtask

  task automatic test_ce_stall();
    int p1, p2, hi, got, held;
    p1 = $urandom_range(2, 4);
    p2 = $urandom_range(12, 14);
    @(negedge clk);
    s0_r = 6'd42; s1_r = 6'd21; n = 6'd0; start_final_addition = 1'b1; ce = 1'b1;
    @(negedge clk);
    start_final_addition = 1'b0;
    hi = 0; got = 0;
    for (int i = 1; i <= 60; i++) begin
      ce = !((i >= p1 && i <= p1 + 2) || (i >= p2 && i <= p2 + 2));
      @(negedge clk);
      if (ce) hi++;
      if (done) begin got = 1; break; end
    end
    checks++;
    if (got !== 1 || hi !== 13) begin
      errors++; $display("FAIL ce_latency actual=%0d got=%0d required=13", hi, got);
    end
    checks++;
    if (m !== 6'd63) begin errors++; $display("FAIL ce_m actual=%0d required=63", m); end
    ce = 1'b0;
    held = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) held++;
    end
    checks++;
    if (held !== 3) begin errors++; $display("FAIL ce_done_hold actual=%0d required=3", held); end
    ce = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL ce_done_clear actual=%b required=0", done); end
  endtask

  task automatic test_busy_start();
    int first, dones;
    @(negedge clk);
    s0_r = 6'd1; s1_r = 6'd2; n = 6'd10; start_final_addition = 1'b1;
    @(negedge clk);
    start_final_addition = 1'b0;
    first = 0; dones = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin s0_r = 6'd7; s1_r = 6'd7; n = 6'd3; start_final_addition = 1'b1; end
      if (k == 6) start_final_addition = 1'b0;
      @(negedge clk);
      if (done) begin
        dones++;
        if (first == 0) first = k;
      end
    end
    checks++;
    if (first !== 13 || dones !== 1) begin
      errors++; $display("FAIL busy_start_ignored actual=first%0d count%0d required=first13 count1", first, dones);
    end
    checks++;
    if (m !== 6'd3) begin errors++; $display("FAIL busy_latched_inputs actual=%0d required=3", m); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    @(negedge clk);
    s0_r = 6'd4; s1_r = 6'd6; n = 6'd10; start_final_addition = 1'b1;
    first = 0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin first = k; break; end
    end
    checks++;
    if (first !== 13 || m !== 6'd0) begin
      errors++; $display("FAIL b2b_first actual=%0d lat=%0d required=0 lat=13", m, first);
    end
    s0_r = 6'd10; s1_r = 6'd5; n = 6'd7;
    second = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_final_addition = 1'b0;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_clear actual=%b required=0", done); end
      end
      if (done) begin second = k; break; end
    end
    checks++;
    if (second !== 14 || m !== 6'd8) begin
      errors++; $display("FAIL b2b_second actual=%0d gap=%0d required=8 gap=14", m, second);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, stray;
    @(negedge clk);
    s0_r = 6'd63; s1_r = 6'd1; n = 6'd5; start_final_addition = 1'b1;
    @(negedge clk);
    start_final_addition = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (m !== 6'd0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_op actual=m%0d done%b required=m0 done0", m, done);
    end
    stray = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL rst_no_done actual=%0d required=0", stray); end
    run_op(6'd10, 6'd5, 6'd7, lat);
    checks++;
    if (lat !== 13 || m !== 6'd8) begin
      errors++; $display("FAIL rst_restart actual=%0d lat=%0d required=8 lat=13", m, lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_correction();
    test_ce_stall();
    test_busy_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/final_adder.md
Name: final_adder

Overview:
- Final stage of the Montgomery multiplier datapath. Converts the carry-save pair (s0_r, s1_r) from the modular multiplier array into one binary result m.
- Then applies the conditional Montgomery correction: subtract modulus n if the sum is at least n.
- Operation is bit-serial, LSB first, to keep area small for wide RSA operands. Completion is signalled by a one-cycle done pulse.

Parameters:
- DATA_WIDTH, default 6, operand/modulus/result width in bits (W). Legal range: W >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; when low, all registers hold their values.
- start_final_addition  input  1  start request; sampled on a rising edge with ce=1 while IDLE.
- s0_r  input  W  carry-save operand 0.
- s1_r  input  W  carry-save operand 1.
- n  input  W  modulus.
- done  output  1  registered; one-cycle pulse when m has just been updated.
- m  output  W  registered result.

Behaviour:
- Reset: the design has one clock; reset is synchronous and active-high (rst, sampled on the rising edge of clk).
  - Reset values: state=IDLE, m=0, done=0, internal shift registers, counters and carry/borrow = 0.
  - Reset has priority over ce and start.
  - Reset mid-operation aborts the operation: no done pulse, and m reads 0.
- Clock enable: all non-reset updates happen only on edges with ce=1. Cycle counts below are in ce=1 cycles. done holds its value while ce=0.
- States: IDLE -> ADD -> SUB -> FINISH -> IDLE.
- IDLE:
  - done=0.
  - On start_final_addition=1: load A<=s0_r, B<=s1_r, N<=n, carry<=0, bit counter<=0, then go to ADD.
  - Inputs are sampled only at this edge; later changes to s0_r, s1_r and n are ignored.
- ADD: W cycles.
  - Each cycle: full-add the LSBs of A and B with carry.
  - Shift the sum bit into the MSB of sum register S (right shift). Shift A and B right.
  - Counter increments each cycle. After bit W-1, store the final carry as c_out, reset the counter and go to SUB.
  - After W cycles, S holds (s0_r+s1_r) mod 2^W.
- SUB: W cycles.
  - Each cycle: full-subtract the LSB of N and borrow from the LSB of S, giving a difference bit into register D.
  - Rotate S right, so S is intact after W cycles. Shift N right.
  - After W cycles, store borrow_out and go to FINISH.
- FINISH: one cycle.
  - If c_out=1 or borrow_out=0, the (W+1)-bit sum is >= n: m <= D, i.e. (sum - n) mod 2^W.
  - Otherwise m <= S.
  - done <= 1; go to IDLE.
  - On the next ce edge in IDLE, done returns to 0.
- Latency:
  - Start sampled at edge E0.
  - m and done update at edge E(2W+1): 13 cycles for W=6.
  - done is high for exactly one ce cycle.
- Start handling:
  - start_final_addition asserted while not IDLE is ignored (not queued).
  - start held high through FINISH is seen in IDLE on the next edge, so a new operation starts one cycle after the done edge.
  - The done pulse and the new start edge coincide: done clears on that edge.
- m holds its last result between operations.
- Arithmetic:
  - Unsigned, with a (W+1)-bit intermediate sum.
  - A single conditional subtraction only; no full modular reduction when sum >= 2n.
  - n=0 always selects D, which equals S.

Test Plan:
1. W=6: rst for one edge, then s0_r=6'b101010, s1_r=6'b010101, n=0, start for 1 cycle -> done pulses exactly once 13 cycles after the start edge; m=6'b111111 (63).
2. Overflow with correction: s0_r=63, s1_r=1, n=5 -> sum=64 (c_out=1); m=59 (6'b111011); done 1 cycle.
3. Sum below modulus: s0_r=1, s1_r=2, n=10 -> m=3. Sum equal to modulus: s0_r=4, s1_r=6, n=10 -> m=0.
4. ce toggled low for 3 random cycles mid-ADD and mid-SUB, with s0_r=42, s1_r=21, n=0 -> m=63; done appears at 13 ce-high cycles and stays high while ce=0 during the pulse.
5. Input change and re-start while busy, with s0_r=1, s1_r=2, n=10 latched at start:
   - Change s0_r/s1_r/n and pulse start in the middle of an operation -> result uses the latched values (m=3); only one done.
   - Back-to-back starts: a new start in IDLE after done gives a correct second result.
6. rst asserted during SUB -> m=0, done=0, state IDLE; a subsequent start with s0_r=10, s1_r=5, n=7 -> m=8.
